// File: rtl/multi_counter_file.sv
// Register file of 2**SEL_W counters; one read-modify-write op per cycle, flags registered.
// Define MCF_SAT_EN to make INC/DEC clamp when sat=1; otherwise all arithmetic wraps.
module multi_counter_file #(
  parameter int               WIDTH   = 8,
  parameter int               SEL_W   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    op,
  input  logic [SEL_W-1:0]              rs,
  input  logic [SEL_W-1:0]              rd,
  input  logic [WIDTH-1:0]              in,
  input  logic [WIDTH-1:0]              step,
  input  logic                          sat,
  input  logic [SEL_W-1:0]              rq,
  output logic [WIDTH-1:0]              q,
  output logic [(2**SEL_W)*WIDTH-1:0]   r_all,
  output logic                          ovf,
  output logic                          unf,
  output logic                          zero
);

  localparam int NCNT = 2**SEL_W;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_CLR  = 3'b100,
    OP_COPY = 3'b101,
    OP_SWAP = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  logic [WIDTH-1:0] cnt_q [NCNT];
  logic [WIDTH-1:0] cnt_d [NCNT];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] src, dst_old, res;
  logic [WIDTH:0]   sum, diff;
  logic             wr;
  op_e              op_s;

  assign op_s    = op_e'(op);
  assign src     = cnt_q[rs];
  assign dst_old = cnt_q[rd];
  assign sum     = {1'b0, src} + {1'b0, step};
  assign diff    = {1'b0, src} - {1'b0, step};

`ifndef MCF_SAT_EN
  logic unused_sat;
  assign unused_sat = sat;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = zero_q;
    res    = '0;
    wr     = 1'b0;
    case (op_s)
      OP_LOAD: begin
        res = in;
        wr  = 1'b1;
      end
      OP_INC: begin
        res   = sum[WIDTH-1:0];
        ovf_d = sum[WIDTH];
        wr    = 1'b1;
`ifdef MCF_SAT_EN
        if (sat && sum[WIDTH]) res = '1;
`endif
      end
      OP_DEC: begin
        res   = diff[WIDTH-1:0];
        unf_d = diff[WIDTH];
        wr    = 1'b1;
`ifdef MCF_SAT_EN
        if (sat && diff[WIDTH]) res = '0;
`endif
      end
      OP_CLR: wr = 1'b1;
      OP_COPY, OP_SWAP: begin
        res = src;
        wr  = 1'b1;
      end
      default: ;
    endcase
    if (wr) begin
      cnt_d[rd] = res;
      zero_d    = (res == '0);
    end
    // With rs == rd this writes back the unchanged value, so self-swap is a no-op.
    if (op_s == OP_SWAP) cnt_d[rs] = dst_old;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= RST_VAL;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      zero_q <= zero_d;
    end
  end

  assign q    = cnt_q[rq];
  assign ovf  = ovf_q;
  assign unf  = unf_q;
  assign zero = zero_q;

  for (genvar k = 0; k < NCNT; k++) begin : g_rall
    assign r_all[k*WIDTH +: WIDTH] = cnt_q[k];
  end

endmodule

// File: tb/tb_multi_counter_file.sv
// Scoreboard bench for multi_counter_file (WIDTH=8, SEL_W=3, RST_VAL=0x5A); expectations are hand-computed.
module tb_multi_counter_file;

  localparam int N = 8;

`ifdef MCF_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic        clk, rst, sat;
  logic [2:0]  op, rs, rd, rq;
  logic [7:0]  in_v, step, q;
  logic [63:0] r_all;
  logic        ovf, unf, zero;

  multi_counter_file #(.WIDTH(8), .SEL_W(3), .RST_VAL(8'h5A)) dut (
    .clk(clk), .rst(rst), .op(op), .rs(rs), .rd(rd), .in(in_v), .step(step),
    .sat(sat), .rq(rq), .q(q), .r_all(r_all), .ovf(ovf), .unf(unf), .zero(zero)
  );

  typedef struct {
    int          id;
    logic [63:0] rall;
    logic [7:0]  qv;
    logic        ovf, unf, zero;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [N];
  int         checks = 0;
  int         failures = 0;
  int         step_id = 0;
  event       sample_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic eo, input logic eu, input logic ez);
    exp_t e;
    e.id = step_id;
    for (int k = 0; k < N; k++) e.rall[k*8 +: 8] = m[k];
    e.qv   = m[rq];
    e.ovf  = eo;
    e.unf  = eu;
    e.zero = ez;
    sb.push_back(e);
    step_id++;
  endtask

  task automatic op_chk(input logic [2:0] o, input int s, input int d, input logic [7:0] din,
                        input logic [7:0] stp, input logic st, input logic [7:0] ed,
                        input logic [7:0] es, input logic eo, input logic eu, input logic ez,
                        input int rqv);
    @(negedge clk);
    op = o; rs = s[2:0]; rd = d[2:0]; in_v = din; step = stp; sat = st; rq = rqv[2:0];
    if (o >= 3'd1 && o <= 3'd6) m[d] = ed;
    if (o == 3'd6) m[s] = es;
    push_exp(eo, eu, ez);
  endtask

  task automatic cmp(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s got=%h expected=%h", id, nm, act, exp);
    end
  endtask

  // Monitor: the DUT presents new state after every edge (and asynchronously on reset).
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.id, "r_all", r_all, e.rall);
        cmp(e.id, "q",     {56'd0, q},    {56'd0, e.qv});
        cmp(e.id, "ovf",   {63'd0, ovf},  {63'd0, e.ovf});
        cmp(e.id, "unf",   {63'd0, unf},  {63'd0, e.unf});
        cmp(e.id, "zero",  {63'd0, zero}, {63'd0, e.zero});
      end
    end
  end

  initial begin
    rst = 1'b1; op = 3'd0; rs = 3'd0; rd = 3'd0; in_v = 8'h00; step = 8'h00; sat = 1'b0; rq = 3'd0;
    for (int k = 0; k < N; k++) m[k] = 8'h5A;
    #7;
    push_exp(1'b0, 1'b0, 1'b0);
    -> sample_ev;
    #5 rst = 1'b0;

    //      op    rs rd  in     step   sat   exp_rd exp_rs ovf unf zero rq
    op_chk(3'd1, 0, 2, 8'hFE, 8'h00, 1'b0, 8'hFE, 8'h00, 0, 0, 0, 2);
    op_chk(3'd2, 2, 2, 8'h00, 8'h03, 1'b0, 8'h01, 8'h00, 1, 0, 0, 2);
    op_chk(3'd0, 0, 2, 8'h77, 8'h03, 1'b0, 8'h00, 8'h00, 0, 0, 0, 3);
    op_chk(3'd1, 0, 5, 8'h04, 8'h00, 1'b0, 8'h04, 8'h00, 0, 0, 0, 5);
    op_chk(3'd3, 5, 5, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00, 0, 0, 1, 5);
    op_chk(3'd0, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1, 5);
    op_chk(3'd3, 5, 5, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 0, 1, 0, 5);
    op_chk(3'd3, 5, 5, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 0, 0, 0, 5);
    op_chk(3'd2, 5, 5, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 0, 0, 0, 5);
    op_chk(3'd1, 0, 1, 8'h11, 8'h00, 1'b0, 8'h11, 8'h00, 0, 0, 0, 1);
    op_chk(3'd1, 0, 6, 8'h66, 8'h00, 1'b0, 8'h66, 8'h00, 0, 0, 0, 6);
    op_chk(3'd6, 1, 6, 8'h00, 8'h00, 1'b0, 8'h11, 8'h66, 0, 0, 0, 1);
    op_chk(3'd6, 3, 3, 8'h00, 8'h00, 1'b0, 8'h5A, 8'h5A, 0, 0, 0, 3);
    op_chk(3'd5, 6, 0, 8'h00, 8'h00, 1'b0, 8'h11, 8'h00, 0, 0, 0, 0);
    op_chk(3'd2, 1, 1, 8'h00, 8'hA0, 1'b0, 8'h06, 8'h00, 1, 0, 0, 1);
    op_chk(3'd4, 0, 6, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 1, 6);
    op_chk(3'd7, 0, 2, 8'h99, 8'h05, 1'b0, 8'h00, 8'h00, 0, 0, 1, 2);

    // Asynchronous reset mid-cycle, held across one edge with a LOAD presented.
    @(negedge clk);
    op = 3'd1; rs = 3'd0; rd = 3'd0; in_v = 8'h33; rq = 3'd6;
    #1 rst = 1'b1;
    for (int k = 0; k < N; k++) m[k] = 8'h5A;
    push_exp(1'b0, 1'b0, 1'b0);
    -> sample_ev;
    #2 push_exp(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    op_chk(3'd1, 0, 0, 8'hF0, 8'h00, 1'b0, 8'hF0, 8'h00, 0, 0, 0, 0);

    op_chk(3'd2, 0, 0, 8'h00, 8'h20, 1'b1, SAT_BUILD ? 8'hFF : 8'h10, 8'h00, 1, 0, 0, 0);
    op_chk(3'd3, 0, 0, 8'h00, 8'hFF, 1'b1, SAT_BUILD ? 8'h00 : 8'h11, 8'h00,
           0, !SAT_BUILD, SAT_BUILD, 0);
    op_chk(3'd3, 0, 0, 8'h00, 8'hFF, 1'b1, SAT_BUILD ? 8'h00 : 8'h12, 8'h00,
           0, 1, SAT_BUILD, 0);

    for (int k = 0; k < N; k++)
      op_chk(3'd1, 0, k, 8'(k * 16), 8'h00, 1'b0, 8'(k * 16), 8'h00, 0, 0, (k == 0), k);
    for (int k = 0; k < N; k++)
      op_chk(3'd0, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 0, 0, 0, k);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
